// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW        = 2'd0,
    CHECK_HIGH = 2'd1,
    HIGH       = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronize and debounce a bouncy input; emit a clean level and 1-cycle edge pulses.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_in;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             level_next, rise_next, fall_next;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (sync_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOW;
      cnt       <= '0;
      level_out <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      level_out <= level_next;
      rise      <= rise_next;
      fall      <= fall_next;
    end
  end

  // Pulses default low so every commit lasts exactly one cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level_out;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      LOW: begin
        if (sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_next = HIGH;
            level_next = 1'b1;
            rise_next  = 1'b1;
          end else begin
            state_next = CHECK_HIGH;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      CHECK_HIGH: begin
        if (!sync_in) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!sync_in) begin
          if (STABLE_CYCLES == 1) begin
            state_next = LOW;
            level_next = 1'b0;
            fall_next  = 1'b1;
          end else begin
            state_next = CHECK_LOW;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      CHECK_LOW: begin
        if (sync_in) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state == CHECK_HIGH) || (state == CHECK_LOW);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed-vector bench for input_debouncer (default and single-cycle qualification instances).
module tb_input_debouncer;
  import debounce_pkg::*;

  typedef struct {
    logic       raw;
    logic [3:0] exp; // {level_out, rise, fall, busy}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw0 = 1'b0;
  logic raw1 = 1'b0;
  logic l0, r0, f0, b0;
  logic l1, r1, f1, b1;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  input_debouncer dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw0),
    .level_out(l0), .rise(r0), .fall(f0), .busy(b0)
  );

  input_debouncer #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .raw_in(raw1),
    .level_out(l1), .rise(r1), .fall(f1), .busy(b1)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got {lvl,rise,fall,busy}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input bit sel, input logic raw, input logic [3:0] exp, input string name);
    @(negedge clk);
    if (sel) raw1 = raw;
    else     raw0 = raw;
    @(posedge clk);
    #1;
    if (sel) check(name, {l1, r1, f1, b1}, exp);
    else     check(name, {l0, r0, f0, b0}, exp);
  endtask

  function automatic void add(input logic raw, input logic [3:0] exp);
    vec_t v;
    v.raw = raw;
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    // Rise from reset: raw=1 captured at vector 0, busy 2..4, commit at 5.
    add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
    add(1, 4'b0001); add(1, 4'b1100);
    for (int i = 0; i < 6; i++) add(1, 4'b1000);
    // Fall from HIGH.
    add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(0, 4'b1001);
    add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000); add(0, 4'b0000);
    // Bounce 1,0,1,0,1,0 then low: busy flickers, level never moves.
    add(1, 4'b0000); add(0, 4'b0000); add(1, 4'b0001); add(0, 4'b0000);
    add(1, 4'b0001); add(0, 4'b0000); add(0, 4'b0001); add(0, 4'b0000);
    for (int i = 0; i < 8; i++) add(0, 4'b0000);

    #3;
    check("reset_outputs", {l0, r0, f0, b0}, 4'b0000);
    check("reset_outputs_sc1", {l1, r1, f1, b1}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(0, tbl[i].raw, tbl[i].exp, $sformatf("table[%0d]", i));
    check("bounce_state_low", {2'b00, dut.state}, {2'b00, LOW});

    // Three synchronized high cycles: one short of committing.
    apply(0, 1, 4'b0000, "short3_0");
    apply(0, 1, 4'b0000, "short3_1");
    apply(0, 1, 4'b0001, "short3_2");
    apply(0, 0, 4'b0001, "short3_3");
    apply(0, 0, 4'b0001, "short3_4");
    apply(0, 0, 4'b0000, "short3_5");
    apply(0, 0, 4'b0000, "short3_6");
    apply(0, 0, 4'b0000, "short3_7");

    // Four high cycles: commits, then falls 6 edges after returning low.
    apply(0, 1, 4'b0000, "exact4_0");
    apply(0, 1, 4'b0000, "exact4_1");
    apply(0, 1, 4'b0001, "exact4_2");
    apply(0, 1, 4'b0001, "exact4_3");
    apply(0, 0, 4'b0001, "exact4_4");
    apply(0, 0, 4'b1100, "exact4_5");
    apply(0, 0, 4'b1001, "exact4_6");
    apply(0, 0, 4'b1001, "exact4_7");
    apply(0, 0, 4'b1001, "exact4_8");
    apply(0, 0, 4'b0010, "exact4_9");
    apply(0, 0, 4'b0000, "exact4_10");
    apply(0, 0, 4'b0000, "exact4_11");

    // Asynchronous reset while qualifying a rise.
    apply(0, 1, 4'b0000, "rstmid_0");
    apply(0, 1, 4'b0000, "rstmid_1");
    apply(0, 1, 4'b0001, "rstmid_2");
    apply(0, 1, 4'b0001, "rstmid_3");
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_async_out", {l0, r0, f0, b0}, 4'b0000);
    check("rstmid_async_cnt", 4'(dut.cnt), 4'b0000);
    #1 rst_n = 1'b1;
    apply(0, 1, 4'b0000, "rstrel_0");
    apply(0, 1, 4'b0000, "rstrel_1");
    apply(0, 1, 4'b0001, "rstrel_2");
    apply(0, 1, 4'b0001, "rstrel_3");
    apply(0, 1, 4'b0001, "rstrel_4");
    apply(0, 1, 4'b1100, "rstrel_5");
    apply(0, 1, 4'b1000, "rstrel_6");

    // STABLE_CYCLES=1: commit two edges after capture, busy never set.
    apply(1, 1, 4'b0000, "sc1_rise_0");
    apply(1, 1, 4'b0000, "sc1_rise_1");
    apply(1, 1, 4'b1100, "sc1_rise_2");
    apply(1, 1, 4'b1000, "sc1_rise_3");
    apply(1, 0, 4'b1000, "sc1_fall_0");
    apply(1, 0, 4'b1000, "sc1_fall_1");
    apply(1, 0, 4'b0010, "sc1_fall_2");
    apply(1, 0, 4'b0000, "sc1_fall_3");
    apply(1, 1, 4'b0000, "sc1_glitch_0");
    apply(1, 0, 4'b0000, "sc1_glitch_1");
    apply(1, 0, 4'b1100, "sc1_glitch_2");
    apply(1, 0, 4'b0010, "sc1_glitch_3");
    apply(1, 0, 4'b0000, "sc1_glitch_4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Front-end conditioning stage for asynchronous, bouncy single-bit inputs such as buttons and external strobes. It synchronizes the raw input into the clk domain and filters it: the output level changes only after the synchronized input has held a new value for STABLE_CYCLES consecutive cycles. It produces a clean level plus one-cycle rise/fall pulses. Its level_out is the intended source for the team's downstream edge and pulse detectors.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
STABLE_CYCLES, 4, consecutive equal synchronized samples needed to commit a change; legal range >= 1.
CNT_W, $clog2(STABLE_CYCLES+1), counter width; derived, never overridden.

Ports:
clk  input  1  single clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
raw_in  input  1  asynchronous, possibly bouncing input.
level_out  output  1  debounced level, registered.
rise  output  1  one-cycle pulse; high in the first cycle level_out reads 1.
fall  output  1  one-cycle pulse; high in the first cycle level_out reads 0.
busy  output  1  high while a candidate change is being qualified.

Behaviour:
- Reset: asserting rst_n=0 takes effect immediately, with no clock edge. Sync flops=0, state=LOW, cnt=0, level_out=0, rise=0, fall=0, busy=0.
- sync_in is the last synchronizer flop. raw_in feeds the first flop only; nothing else reads raw_in.
- FSM states: LOW, CHECK_HIGH, HIGH, CHECK_LOW. busy=1 exactly in CHECK_HIGH and CHECK_LOW (registered state decode).
- LOW, sync_in=1:
  - If STABLE_CYCLES==1: go to HIGH and commit (level_out<=1, rise<=1).
  - Otherwise: go to CHECK_HIGH, cnt<=1.
- CHECK_HIGH:
  - sync_in=0: go to LOW, cnt<=0, no pulse (bounce aborted).
  - sync_in=1 and cnt==STABLE_CYCLES-1: go to HIGH, commit.
  - Otherwise: cnt<=cnt+1.
- HIGH and CHECK_LOW are symmetric, with sync_in=0 as the target and fall as the pulse.
- Commit: level_out, rise/fall and the state update on the same edge. rise/fall are cleared on the next edge, so pulse width is always exactly 1 cycle.
- Latency: a clean raw_in change first captured at edge k appears on level_out after edge k+SYNC_STAGES+STABLE_CYCLES-1. With defaults that is the 6th edge counting k.
- A pulse of fewer than STABLE_CYCLES synchronized cycles never changes level_out.
- cnt never exceeds STABLE_CYCLES-1 and never wraps. It is 0 in LOW and HIGH.
- rise and fall are never high in the same cycle. There are never two rises without an intervening fall.
- After reset release with raw_in held at 1: level_out goes 0 to 1 after full latency, with a rise pulse. The reset level is low.
- Reset mid-CHECK: the qualification is discarded and no pulse is produced.

Decomposition:
- Package debounce_pkg: typedef enum state_t {LOW, CHECK_HIGH, HIGH, CHECK_LOW}. Also a localparam default for the synchronizer depth.
- Sub-module sync_chain (parameter STAGES; ports clk, rst_n, d, q): a flop chain with asynchronous active-low clear to 0. It is instantiated once.
- The FSM, counter and output registers live in input_debouncer.

Test Plan:
1. Defaults, after reset drive raw_in=1 at edge k and hold 12 cycles:
   - busy=1 for exactly 3 cycles (after edges k+2..k+4).
   - level_out=1 after edge k+5.
   - rise=1 for exactly that one cycle; fall stays 0.
2. Bounce, raw_in sequence 1,0,1,0,1,0 (one cycle each) then held 0 for 10 cycles:
   - level_out, rise and fall stay 0 throughout.
   - busy pulses, and state returns to LOW.
3. Threshold glitches:
   - raw_in high for 3 cycles: no rise.
   - raw_in high for 4 cycles: level_out=1 and rise once, then fall once 6 edges after raw_in returns to 0.
4. From HIGH, drive raw_in=0 and hold:
   - fall pulses once 6 edges after capture; level_out=0.
   - rise stays 0; busy high for 3 cycles beforehand.
5. Asynchronous reset mid-CHECK_HIGH (rst_n=0 between edges):
   - level_out, busy and cnt are 0 before the next edge.
   - After release with raw_in=1: rise occurs only after the full 6-edge latency.
6. Instance with STABLE_CYCLES=1:
   - raw_in=1 captured at edge k gives level_out=1 and rise after edge k+2.
   - busy never asserts.
